// File: rtl/johnson_pkg.sv
// Shared types and the generic Johnson-code decode function for johnson_decoder.
// Codes are decoded at up to JC_MAX_W stages; callers pass their actual width.
package johnson_pkg;

    localparam int unsigned JC_MAX_W = 16;
    localparam int unsigned JC_DEF_W = 4;
    localparam int unsigned IDX_W    = $clog2(2 * JC_DEF_W);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } jc_state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] idx;
    } jc_dec_t;

    function automatic jc_dec_t jc_decode(
        input logic [JC_MAX_W-1:0] code,
        input int unsigned         w
    );
        jc_dec_t     r;
        int unsigned pc;
        logic [31:0] c32;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] all;
        logic        msb;
        pc = 0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if (i < w) pc += 32'(code[i]);
        end
        c32 = 32'(code);
        msb = c32[w-1];
        // ones packed at the bottom (msb=0) or at the top (msb=1)
        lo  = (32'd1 << pc) - 32'd1;
        all = (32'd1 << w) - 32'd1;
        hi  = all & ~((32'd1 << (w - pc)) - 32'd1);
        r.legal = msb ? (c32 == hi) : (c32 == lo);
        r.idx   = msb ? (2 * w - pc) : pc;
        return r;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code checker: code -> {legal, binary phase index}.
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IW   = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] code_i,
    output logic             legal_o,
    output logic [IW-1:0]    idx_o
);

    jc_dec_t dec;

    assign dec     = jc_decode(JC_MAX_W'(code_i), WIDTH);
    assign legal_o = dec.legal;
    assign idx_o   = IW'(dec.idx);

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code decoder with sequence lock tracking and saturating error count.
// Define JOHNSON_DECODER_HOLD_TOLERANT_EN to accept repeated codes as holds.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned IW       = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     jc_in,
    output logic [IW-1:0]        idx_out,
    output logic                 idx_valid,
    output logic                 code_err,
    output logic                 seq_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
);

`ifdef JOHNSON_DECODER_HOLD_TOLERANT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    localparam logic [IW-1:0] LAST = IW'(2 * WIDTH - 1);
    localparam logic [3:0]    LOCK_LAST = 4'(LOCK_CNT - 1);

    jc_state_e            state_q;
    logic [3:0]           steps_q;
    logic [IW-1:0]        prev_q;
    logic [IW-1:0]        idx_q;
    logic                 idx_valid_q;
    logic                 code_err_q;
    logic                 seq_err_q;
    logic                 locked_q;
    logic [ERR_CNT_W-1:0] err_q;

    logic          legal;
    logic [IW-1:0] idx;
    logic [IW-1:0] prev_nxt;
    logic          step_ok;
    logic          hold;
    logic          code_err_d;
    logic          seq_err_d;

    johnson_code_decode #(
        .WIDTH (WIDTH)
    ) u_dec (
        .code_i  (jc_in),
        .legal_o (legal),
        .idx_o   (idx)
    );

    assign prev_nxt   = (prev_q == LAST) ? '0 : prev_q + 1'b1;
    assign step_ok    = (idx == prev_nxt);
    assign hold       = HOLD_EN && (idx == prev_q);
    assign code_err_d = in_valid && !legal;
    assign seq_err_d  = in_valid && legal && (state_q == LOCKED)
                        && !step_ok && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            steps_q     <= '0;
            prev_q      <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            idx_valid_q <= 1'b0;
            code_err_q  <= code_err_d;
            seq_err_q   <= seq_err_d;
            if ((code_err_d || seq_err_d) && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end
            if (in_valid && !legal) begin
                state_q  <= UNLOCKED;
                steps_q  <= '0;
                locked_q <= 1'b0;
            end else if (in_valid) begin
                idx_valid_q <= 1'b1;
                idx_q       <= idx;
                prev_q      <= idx;
                unique case (state_q)
                    UNLOCKED: begin
                        steps_q <= '0;
                        state_q <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (hold) begin
                            steps_q <= steps_q;
                        end else if (step_ok && steps_q == LOCK_LAST) begin
                            steps_q  <= steps_q + 1'b1;
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end else if (step_ok) begin
                            steps_q <= steps_q + 1'b1;
                        end else begin
                            steps_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!step_ok && !hold) begin
                            steps_q  <= '0;
                            state_q  <= ACQUIRE;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= UNLOCKED;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign idx_out   = idx_q;
    assign idx_valid = idx_valid_q;
    assign code_err  = code_err_q;
    assign seq_err   = seq_err_q;
    assign locked    = locked_q;
    assign err_count = err_q;

endmodule
